alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

- Sequential front end that drives the 32-bit combinational `ALU` block.
- Accepts operation requests on a valid/ready handshake and decodes a 4-bit opcode into the ALU controls (`invertA`, `invertB`, `operation`).
- Holds the operands stable while the ALU settles, then captures `result`/`zero`/`overflow` into a registered response held under a second valid/ready handshake.
- Sits between the instruction-execute control and the `ALU` instance.

## Interface
- `WIDTH`, 32, operand/result width; must match the attached `ALU`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: sequencer can accept a request.
- `req_op` in 4: opcode.
- `req_a` in WIDTH: source 1.
- `req_b` in WIDTH: source 2.
- `alu_src1` out WIDTH: to `ALU` aluSrc1.
- `alu_src2` out WIDTH: to `ALU` aluSrc2.
- `alu_invert_a` out 1: to `ALU` invertA.
- `alu_invert_b` out 1: to `ALU` invertB.
- `alu_operation` out 2: to `ALU` operation.
- `alu_result` in WIDTH: from `ALU` result.
- `alu_zero` in 1: from `ALU` zero.
- `alu_overflow` in 1: from `ALU` overflow.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_result` out WIDTH: captured result.
- `rsp_zero` out 1: captured zero flag.
- `rsp_overflow` out 1: captured overflow flag, masked by opcode.
- `rsp_illegal` out 1: opcode not decoded.
- `op_count` out 16: completed responses, saturating.
- `ovf_count` out 16: responses with `rsp_overflow`=1, saturating.

## Operation
- Opcode decode as `req_op` -> `invert_a`/`invert_b`/`operation`:
  - 0x0 AND -> 0/0/00
  - 0x1 OR -> 0/0/01
  - 0x2 ADD -> 0/0/10
  - 0x6 SUB -> 0/1/10
  - 0x7 SLT -> 0/1/11
  - 0xC NOR -> 1/1/00
  - All other codes are illegal.
- States: IDLE, EXEC, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, register `req_a`/`req_b`/decoded controls onto the `alu_*` outputs.
  - Legal opcode -> EXEC.
  - Illegal opcode -> RESP with `rsp_result`=0, `rsp_zero`=0, `rsp_overflow`=0, `rsp_illegal`=1.
- EXEC:
  - `req_ready`=0.
  - `alu_*` outputs held for one full cycle.
  - At the cycle-ending edge, capture `alu_result` and `alu_zero`; capture `alu_overflow` only for ADD/SUB, otherwise 0.
  - Set `rsp_illegal`=0, then -> RESP.
- RESP:
  - `rsp_valid`=1; all `rsp_*` held stable until `rsp_ready`=1.
  - `req_ready`=`rsp_ready`.
  - On `rsp_ready` with `req_valid`: accept the new request in the same cycle (back-to-back) and go to EXEC, or to RESP if the new opcode is illegal.
  - On `rsp_ready` without `req_valid`: -> IDLE.
- `alu_*` outputs keep their last registered values outside EXEC.
- Counters increment on every `rsp_valid && rsp_ready` and stop at 0xFFFF.

## Timing
- Reset (asynchronous, any state, including mid-EXEC or mid-RESP):
  - state = IDLE; any pending response is dropped.
  - All registered outputs = 0: `alu_*`, `rsp_*`, counters.
  - `rsp_valid`=0; `req_ready`=1 (IDLE).
- `req_ready` and `rsp_valid` are decoded from state only; no combinational path from `req_valid` to them.
- Legal op:
  - accepted at edge N;
  - `alu_*` valid after N;
  - response captured at N+1;
  - `rsp_valid`=1 after N+1.
- Illegal op: `rsp_valid`=1 after N.
- Sustained throughput with `rsp_ready` tied 1: one legal op per 2 cycles.

## Configuration
- `ALU_SEQ_STATS_EN` defined: `op_count`/`ovf_count` counters are built as described.
- Not defined: counters are not instantiated; `op_count` and `ovf_count` are driven constant 0.

## Test plan
- Reset mid-EXEC:
  - Drive `rst_n`=0 asynchronously between edges.
  - Outputs go to 0 immediately, `req_ready`=1, no response appears afterwards.
- ADD 0x2, a=5, b=7:
  - `alu_operation`=10, inverts 0/0.
  - Two edges after acceptance: `rsp_valid`=1, `rsp_result`=12, `rsp_zero`=0, `rsp_overflow`=0.
- SUB 0x6, a=9, b=9: `alu_invert_b`=1, `rsp_result`=0, `rsp_zero`=1.
- ADD overflow, a=0x7FFFFFFF, b=1:
  - `rsp_result`=0x80000000, `rsp_overflow`=1.
  - `ovf_count` increments only with `ALU_SEQ_STATS_EN`.
- Illegal op 0xF: `rsp_valid` one edge after acceptance, `rsp_illegal`=1, `rsp_result`=0.
- Backpressure then back-to-back:
  - Hold `rsp_ready`=0 for 5 cycles; `rsp_*` stays stable and `req_ready`=0.
  - Raise `rsp_ready` with an AND 0x0 request (a=0xF0, b=0x3C) pending; it is accepted the same cycle.
  - Next response `rsp_result`=0x30.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - valid/ready front end for the 32-bit ALU; ALU_SEQ_STATS_EN builds the op/overflow counters
module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic             alu_invert_a,
    output logic             alu_invert_b,
    output logic [1:0]       alu_operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic             rsp_illegal,
    output logic [15:0]      op_count,
    output logic [15:0]      ovf_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] alu_src1_q, alu_src1_d;
    logic [WIDTH-1:0] alu_src2_q, alu_src2_d;
    logic             inv_a_q, inv_a_d;
    logic             inv_b_q, inv_b_d;
    logic [1:0]       oper_q, oper_d;
    logic             ovf_en_q, ovf_en_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             rsp_illegal_q, rsp_illegal_d;

    logic             dec_legal;
    logic             dec_inv_a;
    logic             dec_inv_b;
    logic [1:0]       dec_oper;
    logic             dec_ovf_en;
    logic             load_req;

    // Opcode decode; only ADD and SUB report overflow
    always_comb begin
        dec_legal  = 1'b1;
        dec_inv_a  = 1'b0;
        dec_inv_b  = 1'b0;
        dec_oper   = 2'b00;
        dec_ovf_en = 1'b0;
        case (req_op)
            4'h0: dec_oper = 2'b00;
            4'h1: dec_oper = 2'b01;
            4'h2: begin dec_oper = 2'b10; dec_ovf_en = 1'b1; end
            4'h6: begin dec_inv_b = 1'b1; dec_oper = 2'b10; dec_ovf_en = 1'b1; end
            4'h7: begin dec_inv_b = 1'b1; dec_oper = 2'b11; end
            4'hC: begin dec_inv_a = 1'b1; dec_inv_b = 1'b1; dec_oper = 2'b00; end
            default: dec_legal = 1'b0;
        endcase
    end

    // Handshake outputs depend on state (and rsp_ready in RESP) only
    always_comb begin
        req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
        rsp_valid = (state_q == ST_RESP);
    end

    // Next-state: accept requests, capture the ALU after one settle cycle, hold the response
    always_comb begin
        state_d       = state_q;
        alu_src1_d    = alu_src1_q;
        alu_src2_d    = alu_src2_q;
        inv_a_d       = inv_a_q;
        inv_b_d       = inv_b_q;
        oper_d        = oper_q;
        ovf_en_d      = ovf_en_q;
        rsp_result_d  = rsp_result_q;
        rsp_zero_d    = rsp_zero_q;
        rsp_ovf_d     = rsp_ovf_q;
        rsp_illegal_d = rsp_illegal_q;
        load_req      = 1'b0;
        case (state_q)
            ST_IDLE: load_req = req_valid;
            ST_EXEC: begin
                rsp_result_d  = alu_result;
                rsp_zero_d    = alu_zero;
                rsp_ovf_d     = alu_overflow & ovf_en_q;
                rsp_illegal_d = 1'b0;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (req_valid) load_req = 1'b1;
                    else           state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load_req) begin
            alu_src1_d = req_a;
            alu_src2_d = req_b;
            inv_a_d    = dec_inv_a;
            inv_b_d    = dec_inv_b;
            oper_d     = dec_oper;
            ovf_en_d   = dec_ovf_en;
            if (dec_legal) begin
                state_d = ST_EXEC;
            end else begin
                rsp_result_d  = '0;
                rsp_zero_d    = 1'b0;
                rsp_ovf_d     = 1'b0;
                rsp_illegal_d = 1'b1;
                state_d       = ST_RESP;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_src1_q    <= '0;
            alu_src2_q    <= '0;
            inv_a_q       <= 1'b0;
            inv_b_q       <= 1'b0;
            oper_q        <= 2'b00;
            ovf_en_q      <= 1'b0;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_ovf_q     <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_src1_q    <= alu_src1_d;
            alu_src2_q    <= alu_src2_d;
            inv_a_q       <= inv_a_d;
            inv_b_q       <= inv_b_d;
            oper_q        <= oper_d;
            ovf_en_q      <= ovf_en_d;
            rsp_result_q  <= rsp_result_d;
            rsp_zero_q    <= rsp_zero_d;
            rsp_ovf_q     <= rsp_ovf_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign alu_src1      = alu_src1_q;
    assign alu_src2      = alu_src2_q;
    assign alu_invert_a  = inv_a_q;
    assign alu_invert_b  = inv_b_q;
    assign alu_operation = oper_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_zero      = rsp_zero_q;
    assign rsp_overflow  = rsp_ovf_q;
    assign rsp_illegal   = rsp_illegal_q;

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] ovf_count_q, ovf_count_d;
    logic        rsp_fire;

    // Saturating counters of completed responses and of overflowing responses
    always_comb begin
        rsp_fire    = rsp_valid && rsp_ready;
        op_count_d  = op_count_q;
        ovf_count_d = ovf_count_q;
        if (rsp_fire && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
        if (rsp_fire && rsp_ovf_q && (ovf_count_q != 16'hFFFF)) ovf_count_d = ovf_count_q + 16'd1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q  <= '0;
            ovf_count_q <= '0;
        end else begin
            op_count_q  <= op_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign op_count  = op_count_q;
    assign ovf_count = ovf_count_q;
`else
    assign op_count  = 16'd0;
    assign ovf_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with a behavioural ALU attached
module tb_alu_op_sequencer;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        o;
        logic        il;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [31:0] alu_src1, alu_src2;
    logic        alu_invert_a, alu_invert_b;
    logic [1:0]  alu_operation;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_illegal;
    logic [15:0] op_count, ovf_count;

    int tests = 0;
    int errors = 0;
    int exp_ops = 0;
    int exp_ovf = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_invert_a(alu_invert_a), .alu_invert_b(alu_invert_b),
        .alu_operation(alu_operation),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal),
        .op_count(op_count), .ovf_count(ovf_count)
    );

    // Behavioural MIPS-style ALU: carry-in follows invertB, SLT uses sign xor overflow
    logic [31:0] a_eff, b_eff, sum;
    always_comb begin
        a_eff        = alu_invert_a ? ~alu_src1 : alu_src1;
        b_eff        = alu_invert_b ? ~alu_src2 : alu_src2;
        sum          = a_eff + b_eff + {31'd0, alu_invert_b};
        alu_overflow = (a_eff[31] == b_eff[31]) && (sum[31] != a_eff[31]);
        alu_result   = 32'd0;
        case (alu_operation)
            2'b00: alu_result = a_eff & b_eff;
            2'b01: alu_result = a_eff | b_eff;
            2'b10: alu_result = sum;
            default: alu_result = {31'd0, sum[31] ^ alu_overflow};
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every response handshake pops one expectation
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_rsp: got result 0x%08h expected no response", rsp_result);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rsp_result", rsp_result, mon_e.r);
                chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, mon_e.z});
                chk("rsp_overflow", {31'd0, rsp_overflow}, {31'd0, mon_e.o});
                chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, mon_e.il});
                exp_ops++;
                if (mon_e.o) exp_ovf++;
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic eo, input logic eil);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            errors++;
            $display("FAIL accept_timeout: got req_ready 0 expected 1");
        end else begin
            sb_q.push_back('{r: er, z: ez, o: eo, il: eil});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_alu_src1", alu_src1, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_op_count", {16'd0, op_count}, 32'd0);
        rst_n = 1'b1;

        // Reset in the middle of EXEC drops the operation
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'h2; req_a = 32'd5; req_b = 32'd7;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("exec_alu_src1", alu_src1, 32'd5);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_alu_src1", alu_src1, 32'd0);
        chk("midrst_alu_op", {30'd0, alu_operation}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("postrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // ADD 5+7 with latency checks
        send(4'h2, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("add_operation", {30'd0, alu_operation}, 32'd2);
        chk("add_inv_a", {31'd0, alu_invert_a}, 32'd0);
        chk("add_inv_b", {31'd0, alu_invert_b}, 32'd0);
        chk("add_no_early_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        chk("add_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        send(4'h6, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("sub_inv_b", {31'd0, alu_invert_b}, 32'd1);
        send(4'h2, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        send(4'h7, 32'd3, 32'd5, 32'd1, 1'b0, 1'b0, 1'b0);
        send(4'h7, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1'b0);
        send(4'hC, 32'h0000_000F, 32'h0000_00F0, 32'hFFFF_FF00, 1'b0, 1'b0, 1'b0);

        // Illegal opcode responds one edge after acceptance
        send(4'hF, 32'd123, 32'd456, 32'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ill_rsp_illegal", {31'd0, rsp_illegal}, 32'd1);
        send(4'h3, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1);

        // Backpressure then back-to-back acceptance
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        send(4'h1, 32'h0000_00A0, 32'h0000_000C, 32'h0000_00AC, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'h0; req_a = 32'h0000_00F0; req_b = 32'h0000_003C;
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_result", rsp_result, 32'h0000_00AC);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("b2b_req_ready", {31'd0, req_ready}, 32'd1);
        sb_q.push_back('{r: 32'h0000_0030, z: 1'b0, o: 1'b0, il: 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_exec_alu_a", alu_src1, 32'h0000_00F0);

        begin
            int n = 0;
            while (sb_q.size() != 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        @(negedge clk);
`ifdef ALU_SEQ_STATS_EN
        chk("op_count", {16'd0, op_count}, exp_ops);
        chk("ovf_count", {16'd0, ovf_count}, exp_ovf);
`else
        chk("op_count", {16'd0, op_count}, 32'd0);
        chk("ovf_count", {16'd0, ovf_count}, 32'd0);
`endif
        chk("ovf_seen", exp_ovf, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
